// File: rtl/int2fp_arbiter.sv
// Two-requester front end for a shared int->fp32 converter pipeline.
// Round-robin arbitration, credit-based issue, a tag pipe tracking which
// requester owns each in-flight conversion, and a FWFT result FIFO.
module int2fp_arbiter #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [31:0] s0_data,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [31:0] s1_data,
    output logic [31:0] conv_int_in,
    input  logic [31:0] conv_result,
    input  logic        conv_exception,
    input  logic        conv_overflow,
    input  logic        conv_underflow,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_id,
    output logic [31:0] m_result,
    output logic [2:0]  m_flags,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic [2:0]  flags;
    } entry_t;

    logic               prio_q, prio_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0] tag_id_q, tag_id_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    entry_t             mem_q [DEPTH];

    logic credit_ok, issue, gnt_id, push, pop;
    entry_t head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Arbitration and issue: credits cover both in-flight and buffered
    // results, so anything issued is guaranteed a FIFO slot on arrival.
    // Only registered counts are used, so a pop frees its credit next cycle.
    always_comb begin
        credit_ok   = (32'(inflight_q) + 32'(count_q)) < 32'(DEPTH);
        issue       = rst && credit_ok && (s0_valid || s1_valid);
        gnt_id      = prio_q ? s1_valid : !s0_valid;
        s0_ready    = issue && !gnt_id;
        s1_ready    = issue && gnt_id;
        conv_int_in = '0;
        if (issue) conv_int_in = gnt_id ? s1_data : s0_data;
    end

    // FIFO head presentation (first-word-fall-through) and status
    always_comb begin
        head     = mem_q[rd_ptr_q];
        m_valid  = (count_q != '0);
        m_id     = head.id;
        m_result = head.result;
        m_flags  = head.flags;
        pop      = m_valid && m_ready;
        push     = tag_vld_q[LATENCY-1];
        busy     = (inflight_q != '0) || (count_q != '0);
    end

    // Next-state: pointer rotation, tag shift, occupancy counters
    always_comb begin
        prio_d      = issue ? !gnt_id : prio_q;
        tag_vld_d   = tag_vld_q;
        tag_id_d    = tag_id_q;
        tag_vld_d[0] = issue;
        tag_id_d[0]  = gnt_id;
        for (int i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
        inflight_d = inflight_q + CW'(issue) - CW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    // Control state with synchronous active-low reset; reset drops all
    // in-flight tags and buffered entries so nothing stale emerges later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_q     <= 1'b0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            prio_q     <= prio_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage: capture the converter output when its tag arrives
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{id:     tag_id_q[LATENCY-1],
                                 result: conv_result,
                                 flags:  {conv_exception, conv_overflow, conv_underflow}};
        end
    end

endmodule

// File: tb/tb_int2fp_arbiter.sv
// Bench for int2fp_arbiter: stand-in converter pipeline, queue-based
// reference model checked every cycle, directed literal scenarios, then
// randomized traffic with occasional resets.
module tb_int2fp_arbiter;

    localparam int LAT = 2;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_ready, s1_valid, s1_ready;
    logic [31:0] s0_data, s1_data;
    logic [31:0] conv_int_in, conv_result;
    logic        conv_exception, conv_overflow, conv_underflow;
    logic        m_valid, m_ready, m_id, busy;
    logic [31:0] m_result;
    logic [2:0]  m_flags;
    logic [2:0]  inj_flags;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    int          q_gnt[$];
    logic [35:0] q_rsp[$];

    always #5 clk = ~clk;

    int2fp_arbiter #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
        .conv_int_in(conv_int_in), .conv_result(conv_result),
        .conv_exception(conv_exception), .conv_overflow(conv_overflow),
        .conv_underflow(conv_underflow),
        .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id),
        .m_result(m_result), .m_flags(m_flags), .busy(busy)
    );

    // Round-to-nearest-even signed int32 -> fp32
    function automatic logic [31:0] int2fp(input logic [31:0] x);
        logic        s;
        logic [31:0] a, rem, half;
        logic [23:0] mant;
        logic [7:0]  e;
        int          msb, sh;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        a = s ? (~x + 32'd1) : x;
        msb = 31;
        while (msb > 0 && !a[msb]) msb--;
        e = 8'(127 + msb);
        if (msb <= 23) begin
            mant = 24'(a << (23 - msb));
        end else begin
            sh   = msb - 23;
            mant = 24'(a >> sh);
            rem  = a & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && mant[0])) begin
                mant = mant + 24'd1;
                if (mant == 24'd0) begin
                    mant = 24'h800000;
                    e    = e + 8'd1;
                end
            end
        end
        return {s, e, mant[22:0]};
    endfunction

    // Stand-in converter: LAT register stages. A real int->fp32 never
    // raises its flags, so flags are injected to exercise the capture path.
    logic [34:0] cpipe [LAT];
    always @(posedge clk) begin
        cpipe[0] <= {inj_flags, int2fp(conv_int_in)};
        for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
    assign conv_result = cpipe[LAT-1][31:0];
    assign {conv_exception, conv_overflow, conv_underflow} = cpipe[LAT-1][34:32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted items wait LAT edges, then join an ordered
    // FIFO; credits = DEPTH minus everything accepted and not yet popped.
    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [2:0]  fl;
        int          left;
    } item_t;

    item_t pend[$];
    item_t fifo[$];
    bit    prio = 1'b0;

    always @(negedge clk) begin : cmp
        int    occ;
        bit    iss, w;
        item_t it;
        if (chk_en) begin
            occ = pend.size() + fifo.size();
            iss = rst && (s0_valid || s1_valid) && (occ < DEP);
            w   = prio ? (s1_valid ? 1'b1 : 1'b0) : (s0_valid ? 1'b0 : 1'b1);
            chk("s0_ready", 32'(s0_ready), 32'(iss && !w));
            chk("s1_ready", 32'(s1_ready), 32'(iss && w));
            chk("conv_int_in", conv_int_in, iss ? (w ? s1_data : s0_data) : 32'd0);
            chk("m_valid", 32'(m_valid), 32'(fifo.size() > 0));
            chk("busy", 32'(busy), 32'(occ > 0));
            if (fifo.size() > 0) begin
                chk("m_id", 32'(m_id), 32'(fifo[0].id));
                chk("m_result", m_result, fifo[0].res);
                chk("m_flags", 32'(m_flags), 32'(fifo[0].fl));
            end
            if (!rst) begin
                pend.delete();
                fifo.delete();
                prio = 1'b0;
            end else begin
                if (fifo.size() > 0 && m_ready) void'(fifo.pop_front());
                foreach (pend[i]) pend[i].left--;
                while (pend.size() > 0 && pend[0].left == 0) fifo.push_back(pend.pop_front());
                if (iss) begin
                    it.id   = w;
                    it.res  = int2fp(w ? s1_data : s0_data);
                    it.fl   = inj_flags;
                    it.left = LAT;
                    pend.push_back(it);
                    prio = !w;
                end
            end
        end
    end

    task automatic set_in(input logic v0, input logic [31:0] d0,
                          input logic v1, input logic [31:0] d1, input logic mr);
        s0_valid = v0; s0_data = d0;
        s1_valid = v1; s1_data = d1;
        m_ready  = mr;
    endtask

    // Sample grants/responses for this cycle, then advance one edge
    task automatic tick();
        #1;
        if (s0_ready)      q_gnt.push_back(0);
        else if (s1_ready) q_gnt.push_back(1);
        else               q_gnt.push_back(-1);
        if (m_valid && m_ready) q_rsp.push_back({m_flags, m_id, m_result});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        q_gnt.delete();
        q_rsp.delete();
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, w;
        logic [31:0] exp4 [4];
        exp4[0] = 32'h3F80_0000; exp4[1] = 32'h4000_0000;
        exp4[2] = 32'h4040_0000; exp4[3] = 32'h4080_0000;
        rst = 1'b0;
        inj_flags = 3'b000;
        set_in(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b1;

        // Single conversion of 5 from s0
        set_in(1, 32'd5, 0, 0, 1);
        #1;
        chk("t1_s0_ready", 32'(s0_ready), 32'd1);
        tick();
        set_in(0, 0, 0, 0, 1);
        repeat (LAT - 1) tick();
        chk("t1_early_m_valid", 32'(m_valid), 32'd0);
        tick();
        chk("t1_m_valid", 32'(m_valid), 32'd1);
        chk("t1_m_id", 32'(m_id), 32'd0);
        chk("t1_m_result", m_result, 32'h40A0_0000);
        chk("t1_m_flags", 32'(m_flags), 32'd0);
        tick();

        // Both requesters streaming: grants alternate starting with 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(1, 32'(i * 3 + 1), 1, 32'(-(i + 7)), 1);
            tick();
        end
        set_in(0, 0, 0, 0, 1);
        repeat (LAT + 2) tick();
        for (int i = 0; i < 8; i++) chk("t2_grant", 32'(q_gnt[i]), 32'(i % 2));
        chk("t2_rsp_count", 32'(q_rsp.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_rsp.size(); i++)
            chk("t2_rsp_id", 32'(q_rsp[i][32]), 32'(i % 2));

        // Back-pressure: only DEPTH accepted until the sink drains
        do_reset();
        k = 1;
        for (int i = 0; i < 8; i++) begin
            set_in(1, 32'(k), 0, 0, 0);
            tick();
            if (q_gnt[$] == 0) k++;
        end
        chk("t3_accepted", 32'(k - 1), 32'd4);
        chk("t3_stalled", 32'(q_gnt[$]), 32'hFFFF_FFFF);
        for (int i = 0; i < 12; i++) begin
            set_in(k <= 5, 32'(k), 0, 0, 1);
            tick();
            if (q_gnt[$] == 0) k++;
        end
        chk("t3_fifth_accepted", 32'(k), 32'd6);
        chk("t3_rsp_count", 32'(q_rsp.size()), 32'd5);
        for (int i = 0; i < 4 && i < q_rsp.size(); i++)
            chk("t3_rsp", q_rsp[i][31:0], exp4[i]);
        if (q_rsp.size() > 4) chk("t3_rsp5", q_rsp[4][31:0], 32'h40A0_0000);

        // s1 negative and most-negative operands, order preserved
        do_reset();
        set_in(0, 0, 1, 32'hFFFF_FFFE, 1);
        tick();
        set_in(0, 0, 1, 32'h8000_0000, 1);
        tick();
        set_in(0, 0, 0, 0, 1);
        repeat (LAT + 3) tick();
        chk("t4_rsp_count", 32'(q_rsp.size()), 32'd2);
        if (q_rsp.size() == 2) begin
            chk("t4_id0", 32'(q_rsp[0][32]), 32'd1);
            chk("t4_res0", q_rsp[0][31:0], 32'hC000_0000);
            chk("t4_id1", 32'(q_rsp[1][32]), 32'd1);
            chk("t4_res1", q_rsp[1][31:0], 32'hCF00_0000);
        end

        // Reset with two in flight and two buffered
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'(10 + i), 0, 0, 0);
            tick();
        end
        chk("t5_busy_before", 32'(busy), 32'd1);
        chk("t5_m_valid_before", 32'(m_valid), 32'd1);
        rst = 1'b0;
        set_in(1, 32'd99, 1, 32'd98, 1);
        #1;
        chk("t5_ready_in_reset", 32'(s0_ready | s1_ready), 32'd0);
        tick();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 1);
        #1;
        chk("t5_m_valid_after", 32'(m_valid), 32'd0);
        chk("t5_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            chk("t5_no_ghost", 32'(m_valid), 32'd0);
        end

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 249) != 0);
            inj_flags = 3'($urandom);
            set_in($urandom_range(0, 2) != 0, rnd_data(),
                   $urandom_range(0, 2) != 0, rnd_data(),
                   ((i / 64) % 3 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            tick();
        end

        // Drain with a bounded wait
        rst = 1'b1;
        inj_flags = 3'b000;
        set_in(0, 0, 0, 0, 1);
        w = 0;
        while (busy && w < 50) begin
            tick();
            w++;
        end
        chk("drain_idle", 32'(busy), 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
